// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csa_pkg
// Purpose  : Shared state encoding and index-width helper for csa_sub_seq.
// Revision : 1.0  initial release
// ============================================================================
package csa_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // ceil(log2(n)), never less than one bit so a single-block index still exists
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_sub_block.sv
`default_nettype none
// ============================================================================
// Module   : csa_sub_block
// Purpose  : One M-bit carry-select slice: both carry-in sums, then a 2:1 pick.
// Revision : 1.0  initial release
// ============================================================================
module csa_sub_block #(
    parameter int M = 6
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] nb,
    input  logic         cin,
    output logic [M-1:0] s,
    output logic         cout
);

    logic [M:0] w_sum0;
    logic [M:0] w_sum1;

    assign w_sum0 = {1'b0, a} + {1'b0, nb};
    assign w_sum1 = {1'b0, a} + {1'b0, nb} + {{M{1'b0}}, 1'b1};

    assign s    = cin ? w_sum1[M-1:0] : w_sum0[M-1:0];
    assign cout = cin ? w_sum1[M]     : w_sum0[M];

endmodule
`default_nettype wire

// File: rtl/csa_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : csa_sub_seq
// Purpose  : Sequential carry-select subtractor, Diff = A - B, one block/clock.
// Revision : 1.0  initial release
// ============================================================================
module csa_sub_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int M     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out
);

    localparam int NBLK = WIDTH / M;
    localparam int IW   = clog2_min1(NBLK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);

    state_t state_q, state_d;

    logic [NBLK-1:0][M-1:0] a_q;
    logic [NBLK-1:0][M-1:0] b_q;
    logic [NBLK-1:0][M-1:0] diff_q;
    logic [IW-1:0]          idx_q;
    logic                   carry_q;
    logic                   bout_q;

    logic [M-1:0] w_blk_a;
    logic [M-1:0] w_blk_nb;
    logic [M-1:0] w_blk_s;
    logic         w_blk_cout;

    assign w_blk_a  = a_q[idx_q];
    assign w_blk_nb = ~b_q[idx_q];

    // Single slice reused for every block; idx_q selects which one it sees
    csa_sub_block #(
        .M (M)
    ) u_blk (
        .a    (w_blk_a),
        .nb   (w_blk_nb),
        .cin  (carry_q),
        .s    (w_blk_s),
        .cout (w_blk_cout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        idx_q   <= '0;
                        carry_q <= 1'b1;   // the +1 of A + ~B + 1
                    end
                end
                S_RUN: begin
                    diff_q[idx_q] <= w_blk_s;
                    carry_q       <= w_blk_cout;
                    idx_q         <= idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        bout_q <= ~w_blk_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign Diff  = diff_q;
    assign B_out = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_sub_seq
// Purpose  : Self-checking bench for csa_sub_seq against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_csa_sub_seq;

    localparam int WIDTH = 18;
    localparam int M     = 6;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             B_out;

    int n_checks = 0;
    int n_errors = 0;

    csa_sub_seq #(
        .WIDTH (WIDTH),
        .M     (M)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .B_out (B_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; expected values come from plain modular arithmetic.
    // With disturb set, start is held high with other operands for the whole op.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit disturb);
        int lat;
        int bcnt;
        logic [WIDTH-1:0] exp_diff;
        logic             exp_bout;
        exp_diff = WIDTH'((int'(a) - int'(b)) & ((1 << WIDTH) - 1));
        exp_bout = (int'(a) < int'(b));
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        lat   = 0;
        bcnt  = int'(busy);
        while (!done && lat < 20) begin
            if (disturb) begin
                start = 1'b1;
                A     = WIDTH'(1);
                B     = WIDTH'(2);
            end
            @(negedge clk);
            lat++;
            bcnt += int'(busy);
        end
        check("latency", lat, 3);
        check("busy_cycles", bcnt, 4);
        check("diff", Diff, exp_diff);
        check("borrow", B_out, exp_bout);
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", Diff, 0);
        check("rst_bout", B_out, 0);
        rst = 1'b0;

        do_op(18'd100, 18'd55, 0);
        @(negedge clk);
        check("post_done_busy", busy, 0);
        check("post_done_done", done, 0);
        check("post_done_hold", Diff, 45);

        do_op(18'd5, 18'd16, 0);
        do_op(18'd64, 18'd1, 0);
        do_op(18'd0, 18'd1, 0);

        do_op(18'd65, 18'd65, 0);
        do_op(18'd16, 18'd16, 0);   // starts on the first IDLE cycle

        do_op(18'd100, 18'd100, 1);
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_extra_done", done, 0);
        end
        check("ignored_start_diff", Diff, 0);

        for (int i = 0; i < 24; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            case (i % 6)
                0: a = '0;
                1: b = '1;
                2: b = a;
                3: a = '1;
                default: ;
            endcase
            do_op(a, b, 0);
        end

        do_op(18'd200, 18'd1, 0);
        @(negedge clk);
        start = 1'b1;
        A     = 18'd7;
        B     = 18'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);   // blocks 0 and 1 now processed
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_diff", Diff, 0);
        check("midrun_rst_bout", B_out, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done, 0);
        end
        do_op(18'd55, 18'd5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
